// File: rtl/dense_4_softmax.sv
// rtl/dense_4_softmax.sv - iterative max-subtracted LUT softmax with argmax for 5 class logits
module dense_4_softmax #(
    parameter int N_CLASS   = 5,
    parameter int IN_W      = 16,
    parameter int IN_FRAC   = 10,
    parameter int LUT_FRAC  = 3,
    parameter int LUT_DEPTH = 64,
    parameter int EXP_W     = 10,
    parameter int OUT_W     = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_CLASS*IN_W-1:0]  in_logits,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_CLASS*OUT_W-1:0] out_prob,
    output logic [2:0]               out_class
);

    localparam int SH    = IN_FRAC - LUT_FRAC;
    localparam int SUM_W = EXP_W + 3;
    localparam int AW    = $clog2(LUT_DEPTH);
    localparam int BW    = $clog2(OUT_W);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAX  = 3'd1,
        EXP  = 3'd2,
        DIV  = 3'd3,
        FIN  = 3'd4,
        OUT  = 3'd5
    } state_t;

    state_t                     state;
    logic [2:0]                 cnt;
    logic [BW-1:0]              bit_cnt;
    logic signed [IN_W-1:0]     x_mem [N_CLASS];
    logic [EXP_W-1:0]           e_mem [N_CLASS];
    logic signed [IN_W-1:0]     max_val;
    logic [2:0]                 arg;
    logic [SUM_W-1:0]           sum;
    logic [SUM_W-1:0]           rem;
    logic [OUT_W-1:0]           quo;
    logic [N_CLASS*OUT_W-1:0]   prob_acc;

    // exp(-k/8) scaled by 2^10, first entry clipped to fit 10 bits
    function automatic logic [EXP_W-1:0] exp_rom(input logic [AW-1:0] k);
        logic [EXP_W-1:0] v;
        case (k)
            6'd0:  v = 10'd1023; 6'd1:  v = 10'd904;  6'd2:  v = 10'd797;  6'd3:  v = 10'd704;
            6'd4:  v = 10'd621;  6'd5:  v = 10'd548;  6'd6:  v = 10'd484;  6'd7:  v = 10'd427;
            6'd8:  v = 10'd377;  6'd9:  v = 10'd332;  6'd10: v = 10'd293;  6'd11: v = 10'd259;
            6'd12: v = 10'd228;  6'd13: v = 10'd202;  6'd14: v = 10'd178;  6'd15: v = 10'd157;
            6'd16: v = 10'd139;  6'd17: v = 10'd122;  6'd18: v = 10'd108;  6'd19: v = 10'd95;
            6'd20: v = 10'd84;   6'd21: v = 10'd74;   6'd22: v = 10'd65;   6'd23: v = 10'd58;
            6'd24: v = 10'd51;   6'd25: v = 10'd45;   6'd26: v = 10'd40;   6'd27: v = 10'd35;
            6'd28: v = 10'd31;   6'd29: v = 10'd27;   6'd30: v = 10'd24;   6'd31: v = 10'd21;
            6'd32: v = 10'd19;   6'd33: v = 10'd17;   6'd34: v = 10'd15;   6'd35: v = 10'd13;
            6'd36: v = 10'd11;   6'd37: v = 10'd10;   6'd38: v = 10'd9;    6'd39: v = 10'd8;
            6'd40: v = 10'd7;    6'd41: v = 10'd6;    6'd42: v = 10'd5;    6'd43: v = 10'd5;
            6'd44: v = 10'd4;    6'd45: v = 10'd4;    6'd46: v = 10'd3;    6'd47: v = 10'd3;
            6'd48: v = 10'd3;    6'd49: v = 10'd2;    6'd50: v = 10'd2;    6'd51: v = 10'd2;
            6'd52: v = 10'd2;    6'd53: v = 10'd1;    6'd54: v = 10'd1;    6'd55: v = 10'd1;
            6'd56: v = 10'd1;    6'd57: v = 10'd1;    6'd58: v = 10'd1;    6'd59: v = 10'd1;
            6'd60: v = 10'd1;
            default: v = 10'd0;
        endcase
        return v;
    endfunction

    // Element currently addressed by the shared counter
    logic signed [IN_W-1:0] x_cur;
    assign x_cur = x_mem[cnt];

    // Distance below the max is never negative, so one extra bit suffices
    logic [IN_W:0] diff;
    logic [IN_W:0] lut_idx;
    logic [EXP_W-1:0] e_cur;
    assign diff    = {max_val[IN_W-1], max_val} - {x_cur[IN_W-1], x_cur};
    assign lut_idx = diff >> SH;
    assign e_cur   = (lut_idx < (IN_W+1)'(LUT_DEPTH)) ? exp_rom(lut_idx[AW-1:0]) : '0;

    // One restoring-division step; starting from e==sum yields all ones, which is the saturated result
    logic [SUM_W-1:0] r_cur;
    logic [SUM_W:0]   r_shift;
    logic [SUM_W:0]   r_sub;
    logic             q_bit;
    logic [SUM_W-1:0] r_next;
    logic [OUT_W-1:0] q_next;
    assign r_cur   = (bit_cnt == '0) ? SUM_W'(e_mem[cnt]) : rem;
    assign r_shift = {r_cur, 1'b0};
    assign r_sub   = r_shift - {1'b0, sum};
    assign q_bit   = (r_shift >= {1'b0, sum});
    assign r_next  = q_bit ? r_sub[SUM_W-1:0] : r_shift[SUM_W-1:0];
    assign q_next  = {quo[OUT_W-2:0], q_bit};

    // Control FSM plus datapath registers: MAX, EXP and DIV each walk the classes in order
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_prob  <= '0;
            out_class <= '0;
            cnt       <= '0;
            bit_cnt   <= '0;
            max_val   <= '0;
            arg       <= '0;
            sum       <= '0;
            rem       <= '0;
            quo       <= '0;
            prob_acc  <= '0;
            for (int i = 0; i < N_CLASS; i++) begin
                x_mem[i] <= '0;
                e_mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N_CLASS; i++) begin
                            x_mem[i] <= in_logits[i*IN_W +: IN_W];
                        end
                        cnt      <= '0;
                        sum      <= '0;
                        in_ready <= 1'b0;
                        state    <= MAX;
                    end
                end
                MAX: begin
                    // strict compare keeps the lowest index on ties
                    if (cnt == '0 || x_cur > max_val) begin
                        max_val <= x_cur;
                        arg     <= cnt;
                    end
                    if (cnt == 3'(N_CLASS-1)) begin
                        cnt   <= '0;
                        state <= EXP;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                EXP: begin
                    e_mem[cnt] <= e_cur;
                    sum        <= sum + SUM_W'(e_cur);
                    if (cnt == 3'(N_CLASS-1)) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= DIV;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                DIV: begin
                    rem <= r_next;
                    quo <= q_next;
                    if (bit_cnt == BW'(OUT_W-1)) begin
                        prob_acc[cnt*OUT_W +: OUT_W] <= q_next;
                        bit_cnt <= '0;
                        if (cnt == 3'(N_CLASS-1)) begin
                            cnt   <= '0;
                            state <= FIN;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                FIN: begin
                    out_prob  <= prob_acc;
                    out_class <= arg;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dense_4_softmax.sv
// tb/tb_dense_4_softmax.sv - directed self-checking bench for dense_4_softmax
module tb_dense_4_softmax;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [79:0] in_logits;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_prob;
    logic [2:0]  out_class;

    int pass_cnt;
    int total_cnt;

    dense_4_softmax dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_logits (in_logits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prob  (out_prob),
        .out_class (out_class)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [79:0] pack5(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [15:0] d,
                                          input logic [15:0] e);
        return {e, d, c, b, a};
    endfunction

    // Drive one vector through the accept edge and count edges until out_valid
    task automatic send_vector(input logic [79:0] v, output int lat);
        @(negedge clk);
        in_logits = v;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_logits = pack5(16'h7FFF, 16'h8000, 16'h1234, 16'h0000, 16'h7000);
        lat = 0;
        while (lat < 200 && !out_valid) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_logits = '0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0d want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0d want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_prob !== 40'd0) $display("FAIL reset_out_prob got %h want 0", out_prob); else pass_cnt++;
        total_cnt++; if (out_class !== 3'd0) $display("FAIL reset_out_class got %0d want 0", out_class); else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_prob !== 40'd0 || out_class !== 3'd0)
                $display("FAIL idle_cycle_%0d got rdy=%0d vld=%0d prob=%h cls=%0d want 1 0 0 0",
                         i, in_ready, out_valid, out_prob, out_class);
            else pass_cnt++;
        end
    endtask

    task automatic test_equal();
        int lat;
        logic [7:0] ep [5];
        ep = '{8'd51, 8'd51, 8'd51, 8'd51, 8'd51};
        send_vector(pack5(16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400), lat);
        total_cnt++; if (lat !== 51) $display("FAIL equal_latency got %0d want 51", lat); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (out_prob[i*8 +: 8] !== ep[i]) $display("FAIL equal_p%0d got %0d want %0d", i, out_prob[i*8 +: 8], ep[i]);
            else pass_cnt++;
        end
        total_cnt++; if (out_class !== 3'd0) $display("FAIL equal_class got %0d want 0", out_class); else pass_cnt++;
        drain();
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL equal_handshake got vld=%0d rdy=%0d want 0 1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_dominant();
        int lat;
        logic [7:0] ep [5];
        ep = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
        send_vector(pack5(16'h1000, 16'hE000, 16'hE000, 16'hE000, 16'hE000), lat);
        total_cnt++; if (lat !== 51) $display("FAIL dominant_latency got %0d want 51", lat); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (out_prob[i*8 +: 8] !== ep[i]) $display("FAIL dominant_p%0d got %0d want %0d", i, out_prob[i*8 +: 8], ep[i]);
            else pass_cnt++;
        end
        total_cnt++; if (out_class !== 3'd0) $display("FAIL dominant_class got %0d want 0", out_class); else pass_cnt++;
        drain();
    endtask

    task automatic test_tie();
        int lat;
        logic [7:0] ep [5];
        ep = '{8'd0, 8'd0, 8'd128, 8'd0, 8'd128};
        send_vector(pack5(16'hC000, 16'hC000, 16'h0800, 16'hC000, 16'h0800), lat);
        total_cnt++; if (lat !== 51) $display("FAIL tie_latency got %0d want 51", lat); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (out_prob[i*8 +: 8] !== ep[i]) $display("FAIL tie_p%0d got %0d want %0d", i, out_prob[i*8 +: 8], ep[i]);
            else pass_cnt++;
        end
        total_cnt++; if (out_class !== 3'd2) $display("FAIL tie_class got %0d want 2", out_class); else pass_cnt++;
        drain();
    endtask

    task automatic test_two_hot();
        int lat;
        logic [7:0] ep [5];
        ep = '{8'd187, 8'd68, 8'd0, 8'd0, 8'd0};
        send_vector(pack5(16'h0800, 16'h0400, 16'hC000, 16'hC000, 16'hC000), lat);
        total_cnt++; if (lat !== 51) $display("FAIL two_hot_latency got %0d want 51", lat); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (out_prob[i*8 +: 8] !== ep[i]) $display("FAIL two_hot_p%0d got %0d want %0d", i, out_prob[i*8 +: 8], ep[i]);
            else pass_cnt++;
        end
        total_cnt++; if (out_class !== 3'd0) $display("FAIL two_hot_class got %0d want 0", out_class); else pass_cnt++;
        drain();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [39:0] ep;
        ep = {8'd0, 8'd0, 8'd0, 8'd68, 8'd187};
        send_vector(pack5(16'h0800, 16'h0400, 16'hC000, 16'hC000, 16'hC000), lat);
        total_cnt++; if (lat !== 51) $display("FAIL bp_latency got %0d want 51", lat); else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_logits = pack5(16'h0000, 16'h2000, 16'h0000, 16'h0000, 16'h0000);
            @(posedge clk);
            #1;
            total_cnt++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_prob !== ep || out_class !== 3'd0)
                $display("FAIL bp_hold_%0d got vld=%0d rdy=%0d prob=%h cls=%0d want 1 0 %h 0",
                         i, out_valid, in_ready, out_prob, out_class, ep);
            else pass_cnt++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release got vld=%0d rdy=%0d want 0 1", out_valid, in_ready);
        else pass_cnt++;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_prob !== ep || out_class !== 3'd0)
                $display("FAIL bp_ignored_%0d got vld=%0d rdy=%0d prob=%h cls=%0d want 0 1 %h 0",
                         i, out_valid, in_ready, out_prob, out_class, ep);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_div();
        int lat;
        logic [7:0] ep [5];
        ep = '{8'd0, 8'd0, 8'd128, 8'd0, 8'd128};
        @(negedge clk);
        in_logits = pack5(16'h1000, 16'hE000, 16'hE000, 16'hE000, 16'hE000);
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_reset_out_valid got %0d want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL mid_reset_in_ready got %0d want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_prob !== 40'd0) $display("FAIL mid_reset_out_prob got %h want 0", out_prob); else pass_cnt++;
        send_vector(pack5(16'hC000, 16'hC000, 16'h0800, 16'hC000, 16'h0800), lat);
        total_cnt++; if (lat !== 51) $display("FAIL after_reset_latency got %0d want 51", lat); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (out_prob[i*8 +: 8] !== ep[i]) $display("FAIL after_reset_p%0d got %0d want %0d", i, out_prob[i*8 +: 8], ep[i]);
            else pass_cnt++;
        end
        total_cnt++; if (out_class !== 3'd2) $display("FAIL after_reset_class got %0d want 2", out_class); else pass_cnt++;
        drain();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_idle();
        test_equal();
        test_dominant();
        test_tie();
        test_two_hot();
        test_backpressure();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
